// File: rtl/byte_write_ram_pkg.sv
// Shared types and address-geometry helpers for the byte-write simple dual-port RAM.
package byte_write_ram_pkg;

    typedef enum logic {
        READ_FIRST  = 1'b0,
        WRITE_FIRST = 1'b1
    } rdw_mode_e;

    function automatic int unsigned lane_count(input int unsigned data_width,
                                               input int unsigned byte_width);
        return data_width / byte_width;
    endfunction

    // Byte-offset bits below the word index.
    function automatic int unsigned lane_addr_bits(input int unsigned data_width,
                                                   input int unsigned byte_width);
        return $clog2(data_width / byte_width);
    endfunction

    function automatic int unsigned word_idx_bits(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/byte_write_ram_core.sv
// Storage array with per-lane write and an enabled, registered read port (no reset).
module byte_write_ram_core
    import byte_write_ram_pkg::*;
#(
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BYTE_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             we,
    input  logic [$clog2(DEPTH)-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0]            wdata,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wstrb,
    input  logic                             re,
    input  logic [$clog2(DEPTH)-1:0]         raddr,
    output logic [DATA_WIDTH-1:0]            rdata
);

    localparam int unsigned LANES = lane_count(DATA_WIDTH, BYTE_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Read sees the pre-write contents on a same-edge collision.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                if (wstrb[l]) begin
                    mem[waddr][l*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[l*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/byte_write_sdpram_pipe.sv
// Byte-strobed simple dual-port RAM with a valid/ready read pipeline of 1 or 2 stages.
module byte_write_sdpram_pipe
    import byte_write_ram_pkg::*;
#(
    parameter int unsigned ADDR_DEPTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned BYTE_WIDTH   = 8,
    parameter int unsigned READ_LATENCY = 1,
    parameter rdw_mode_e   RDW_MODE     = READ_FIRST
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  logic [ADDR_WIDTH-1:0]            wr_address,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_strb,
    input  logic                             rd_req_valid,
    output logic                             rd_req_ready,
    input  logic [ADDR_WIDTH-1:0]            rd_address,
    output logic                             rd_resp_valid,
    input  logic                             rd_resp_ready,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_error
);

    localparam int unsigned LANES = lane_count(DATA_WIDTH, BYTE_WIDTH);
    localparam int unsigned LSB   = lane_addr_bits(DATA_WIDTH, BYTE_WIDTH);
    localparam int unsigned IW    = word_idx_bits(ADDR_DEPTH);
    localparam int unsigned HI    = LSB + IW;

    logic [IW-1:0]         wr_idx;
    logic [IW-1:0]         rd_idx;
    logic                  wr_oor;
    logic                  rd_oor;
    logic                  mem_we;
    logic                  rd_accept;
    logic                  byp_hit;
    logic [DATA_WIDTH-1:0] wr_mask;
    logic [DATA_WIDTH-1:0] mem_q;

    logic                  s1_valid;
    logic                  s1_err;
    logic [DATA_WIDTH-1:0] s1_byp_mask;
    logic [DATA_WIDTH-1:0] s1_byp_data;
    logic [DATA_WIDTH-1:0] s1_data;

    logic                  out_valid;
    logic                  out_err;
    logic [DATA_WIDTH-1:0] out_data;

    assign wr_idx = wr_address[HI-1:LSB];
    assign rd_idx = rd_address[HI-1:LSB];

    if (ADDR_WIDTH > HI) begin : g_range
        assign wr_oor = |wr_address[ADDR_WIDTH-1:HI];
        assign rd_oor = |rd_address[ADDR_WIDTH-1:HI];
    end else begin : g_full_range
        assign wr_oor = 1'b0;
        assign rd_oor = 1'b0;
    end

    if (LSB > 0) begin : g_lane_bits
        logic unused_lane_bits;
        assign unused_lane_bits = ^{wr_address[LSB-1:0], rd_address[LSB-1:0]};
    end

    assign mem_we    = wr_en & ~wr_oor & rst_n;
    assign rd_accept = rd_req_valid & rd_req_ready & rst_n;
    assign byp_hit   = (RDW_MODE == WRITE_FIRST) && mem_we && !rd_oor && (wr_idx == rd_idx);

    always_comb begin
        wr_mask = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            wr_mask[l*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{wr_strb[l]}};
        end
    end

    byte_write_ram_core #(
        .DEPTH      (ADDR_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_core (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_idx),
        .wdata (wr_data),
        .wstrb (wr_strb),
        .re    (rd_accept),
        .raddr (rd_idx),
        .rdata (mem_q)
    );

    // Stage 1 is the core's read register; the collision lanes ride alongside it
    // and are merged on the way out, so a stalled entry never sees later writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_err      <= 1'b0;
            s1_byp_mask <= '0;
            s1_byp_data <= '0;
        end else if (rd_req_ready) begin
            s1_valid    <= rd_accept;
            s1_err      <= rd_accept & rd_oor;
            s1_byp_mask <= (rd_accept && byp_hit) ? wr_mask : '0;
            s1_byp_data <= wr_data;
        end
    end

    assign s1_data = s1_err ? '0 : ((mem_q & ~s1_byp_mask) | (s1_byp_data & s1_byp_mask));

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  s2_valid;
        logic                  s2_err;
        logic [DATA_WIDTH-1:0] s2_data;
        logic                  s2_free;

        assign s2_free      = ~s2_valid | rd_resp_ready;
        assign rd_req_ready = ~s1_valid | s2_free;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_valid <= 1'b0;
                s2_err   <= 1'b0;
                s2_data  <= '0;
            end else if (s2_free) begin
                s2_valid <= s1_valid;
                s2_err   <= s1_err;
                s2_data  <= s1_data;
            end
        end

        assign out_valid = s2_valid;
        assign out_err   = s2_err;
        assign out_data  = s2_data;
    end else begin : g_lat1
        assign rd_req_ready = ~s1_valid | rd_resp_ready;
        assign out_valid    = s1_valid;
        assign out_err      = s1_err;
        assign out_data     = s1_data;
    end

    assign rd_resp_valid = out_valid;
    assign rd_error      = out_valid & out_err;
    assign rd_data       = out_valid ? out_data : '0;

endmodule

// File: tb/tb_byte_write_sdpram_pipe.sv
// Bench: two instances (latency 1 / READ_FIRST and latency 2 / WRITE_FIRST) against a queue model.
module tb_byte_write_sdpram_pipe;
    import byte_write_ram_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [31:0] wr_address;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        rd_req_valid;
    logic        rd_resp_ready;
    logic [31:0] rd_address;

    logic        rdy [2];
    logic        vld [2];
    logic        err [2];
    logic [31:0] dat [2];

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          t;
    } ent_t;

    ent_t        q0[$];
    ent_t        q1[$];
    logic [31:0] mem_m [32];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    byte_write_sdpram_pipe #(
        .ADDR_DEPTH(32), .ADDR_WIDTH(32), .DATA_WIDTH(32), .BYTE_WIDTH(8),
        .READ_LATENCY(1), .RDW_MODE(READ_FIRST)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_address(wr_address),
        .wr_data(wr_data), .wr_strb(wr_strb), .rd_req_valid(rd_req_valid),
        .rd_req_ready(rdy[0]), .rd_address(rd_address), .rd_resp_valid(vld[0]),
        .rd_resp_ready(rd_resp_ready), .rd_data(dat[0]), .rd_error(err[0])
    );

    byte_write_sdpram_pipe #(
        .ADDR_DEPTH(32), .ADDR_WIDTH(32), .DATA_WIDTH(32), .BYTE_WIDTH(8),
        .READ_LATENCY(2), .RDW_MODE(WRITE_FIRST)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_address(wr_address),
        .wr_data(wr_data), .wr_strb(wr_strb), .rd_req_valid(rd_req_valid),
        .rd_req_ready(rdy[1]), .rd_address(rd_address), .rd_resp_valid(vld[1]),
        .rd_resp_ready(rd_resp_ready), .rd_data(dat[1]), .rd_error(err[1])
    );

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cycle=%0d got=%h expected=%h", nm, k, cyc, act, exp);
        end
    endtask

    task automatic idle();
        wr_en        = 1'b0;
        wr_address   = '0;
        wr_data      = '0;
        wr_strb      = '0;
        rd_req_valid = 1'b0;
        rd_address   = '0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_en      = 1'b1;
        wr_address = a;
        wr_data    = d;
        wr_strb    = s;
    endtask

    // Compare outputs against the in-order model, then advance model and clock one edge.
    task automatic step();
        logic [31:0] m, old, mrg;
        logic        r_oor, w_ok;
        logic [4:0]  ridx, widx;
        #1;
        m = '0;
        for (int l = 0; l < 4; l++) if (wr_strb[l]) m[l*8 +: 8] = 8'hFF;
        r_oor = (rd_address >> 7) != 0;
        ridx  = rd_address[6:2];
        widx  = wr_address[6:2];
        w_ok  = wr_en && rst_n && ((wr_address >> 7) == 0);
        old   = mem_m[ridx];
        mrg   = (old & ~m) | (wr_data & m);
        for (int k = 0; k < 2; k++) begin
            int   n;
            ent_t h;
            ent_t e;
            bit   ev, er;
            h = '{32'h0, 1'b0, 0};
            n = (k == 0) ? q0.size() : q1.size();
            if (n > 0) h = (k == 0) ? q0[0] : q1[0];
            ev = (n > 0) && ((cyc - h.t) >= lat(k));
            er = (n < lat(k)) || rd_resp_ready;
            chk("rd_req_ready", k, 32'(rdy[k]), 32'(er));
            chk("rd_resp_valid", k, 32'(vld[k]), 32'(ev));
            if (ev) begin
                chk("rd_data", k, dat[k], h.d);
                chk("rd_error", k, 32'(err[k]), 32'(h.e));
                if (rd_resp_ready) begin
                    if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                end
            end
            if (rd_req_valid && er && rst_n) begin
                e.d = r_oor ? 32'h0 : ((k == 1 && w_ok && widx == ridx) ? mrg : old);
                e.e = r_oor;
                e.t = cyc;
                if (k == 0) q0.push_back(e); else q1.push_back(e);
            end
        end
        if (w_ok) mem_m[widx] = (mem_m[widx] & ~m) | (wr_data & m);
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Issue one read with responses held, then pin both held responses to literals.
    task automatic read_hold(input string nm, input logic [31:0] a, input logic [31:0] e0,
                             input logic [31:0] e1, input logic ee);
        rd_req_valid  = 1'b1;
        rd_address    = a;
        rd_resp_ready = 1'b0;
        step();
        idle();
        step();
        for (int k = 0; k < 2; k++) begin
            chk({nm, "_valid"}, k, 32'(vld[k]), 32'h1);
            chk({nm, "_error"}, k, 32'(err[k]), 32'(ee));
        end
        chk({nm, "_data"}, 0, dat[0], e0);
        chk({nm, "_data"}, 1, dat[1], e1);
        rd_resp_ready = 1'b1;
        step();
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return $urandom;
        return 32'($urandom_range(0, 159));
    endfunction

    initial begin
        idle();
        rd_resp_ready = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("reset_valid", k, 32'(vld[k]), 32'h0);
            chk("reset_error", k, 32'(err[k]), 32'h0);
            chk("reset_data", k, dat[k], 32'h0);
        end
        step();
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) begin
            wr(32'(i * 4), $urandom, 4'hF);
            step();
        end
        wr(32'h00, 32'hCAFEF00D, 4'hF); step();
        wr(32'h04, 32'h0BADF00D, 4'hF); step();

        wr(32'h08, 32'hDEADBEEF, 4'hF); step();
        wr(32'h08, 32'h11223344, 4'h5); step();
        idle();
        read_hold("strobe_merge", 32'h08, 32'hDE22BE44, 32'hDE22BE44, 1'b0);

        wr(32'h80, 32'hFFFFFFFF, 4'hF); step();
        idle();
        read_hold("oor_read", 32'h80, 32'h0, 32'h0, 1'b1);
        read_hold("oor_write_word0", 32'h00, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0);

        wr(32'h10, 32'h12345678, 4'hF); step();
        wr(32'h10, 32'hAAAAAAAA, 4'h3);
        read_hold("rdw_collision", 32'h10, 32'h12345678, 32'h1234AAAA, 1'b0);

        idle();
        rd_resp_ready = 1'b1;
        rd_req_valid = 1'b1; rd_address = 32'h00; step();
        chk("lat2_plus1_valid", 1, 32'(vld[1]), 32'h0);
        rd_address = 32'h04; step();
        chk("lat2_plus2_data", 1, dat[1], 32'hCAFEF00D);
        rd_address = 32'h08; step();
        chk("lat2_plus3_data", 1, dat[1], 32'h0BADF00D);
        idle(); step();
        chk("lat2_plus4_data", 1, dat[1], 32'hDE22BE44);
        step();

        for (int i = 0; i < 12; i++) begin
            if (i == 8) begin
                chk("stall_ready_low", 0, 32'(rdy[0]), 32'h0);
                chk("stall_ready_low", 1, 32'(rdy[1]), 32'h0);
            end
            rd_req_valid  = 1'b1;
            rd_address    = 32'(i * 4);
            rd_resp_ready = !(i >= 3 && i < 8);
            step();
        end
        idle();
        rd_resp_ready = 1'b1;
        repeat (6) step();

        rd_req_valid = 1'b1; rd_address = 32'h00; step();
        rd_address = 32'h04; step();
        rd_address = 32'h0C;
        wr(32'h08, 32'h55555555, 4'hF);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("async_reset_valid", k, 32'(vld[k]), 32'h0);
            chk("async_reset_data", k, dat[k], 32'h0);
        end
        q0.delete();
        q1.delete();
        step();
        step();
        rst_n = 1'b1;
        idle();
        repeat (4) step();
        read_hold("write_in_reset", 32'h08, 32'hDE22BE44, 32'hDE22BE44, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            wr_en         = ($urandom_range(0, 1) == 1);
            wr_address    = rand_addr();
            wr_data       = $urandom;
            wr_strb       = 4'($urandom);
            rd_req_valid  = ($urandom_range(0, 9) < 7);
            rd_address    = ($urandom_range(0, 3) == 0) ? wr_address : rand_addr();
            rd_resp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        idle();
        rd_resp_ready = 1'b1;
        repeat (8) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/byte_write_sdpram_pipe.md
BYTE_WRITE_SDPRAM_PIPE -- requirements
Module: byte_write_sdpram_pipe

Interface
REQ-001 SHALL have parameter ADDR_DEPTH, default 32, number of words, power of two, at least 2.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, word width, an integer multiple of BYTE_WIDTH.
REQ-004 SHALL have parameter BYTE_WIDTH, default 8, strobe granularity in bits.
REQ-005 SHALL have parameter READ_LATENCY, default 1, legal values 1 or 2, cycles from accepted request to response valid.
REQ-006 SHALL have parameter RDW_MODE, default READ_FIRST, values READ_FIRST or WRITE_FIRST, same-word read/write result.
REQ-007 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port wr_en, input, 1, write request, always accepted.
REQ-010 SHALL have port wr_address, input, ADDR_WIDTH, byte address of the write.
REQ-011 SHALL have port wr_data, input, DATA_WIDTH, write word.
REQ-012 SHALL have port wr_strb, input, DATA_WIDTH/BYTE_WIDTH, per-lane write enable.
REQ-013 SHALL have port rd_req_valid, input, 1, read request.
REQ-014 SHALL have port rd_req_ready, output, 1, read request accepted when high with rd_req_valid.
REQ-015 SHALL have port rd_address, input, ADDR_WIDTH, byte address of the read.
REQ-016 SHALL have port rd_resp_valid, output, 1, response available.
REQ-017 SHALL have port rd_resp_ready, input, 1, consumer accepts response.
REQ-018 SHALL have port rd_data, output, DATA_WIDTH, response word.
REQ-019 SHALL have port rd_error, output, 1, response address was out of range.

Function
REQ-020 Word index SHALL be address bits [clog2(ADDR_DEPTH)+clog2(DATA_WIDTH/BYTE_WIDTH)-1 : clog2(DATA_WIDTH/BYTE_WIDTH)]; low bits ignored.
REQ-021 Address SHALL be out of range when any bit above the word index is set.
REQ-022 Write with wr_en=1 and in-range address SHALL update exactly the lanes whose wr_strb bit is 1, at that clock edge.
REQ-023 Out-of-range write SHALL leave memory unchanged; no error reported.
REQ-024 The pipeline SHALL have READ_LATENCY stages, each with a valid bit; a stage advances when its successor is empty or advancing; the last stage advances on rd_resp_ready.
REQ-025 rd_req_ready SHALL be high when stage 1 is empty or advancing, and combinational from rd_resp_ready and stage valids only.
REQ-026 Accepted request SHALL produce rd_resp_valid exactly READ_LATENCY cycles later when rd_resp_ready is held high, giving full throughput of one response per cycle.
REQ-027 While rd_resp_valid=1 and rd_resp_ready=0, rd_data, rd_error and rd_resp_valid SHALL hold stable.
REQ-028 Responses SHALL be returned in request order; none dropped or duplicated.
REQ-029 Same-edge write and accepted read of the same in-range word: READ_FIRST SHALL return pre-write data; WRITE_FIRST SHALL return strobed lanes from wr_data and other lanes from old data.
REQ-030 A write to a word held in a stalled stage SHALL NOT alter that stage's captured data.
REQ-031 Out-of-range read SHALL return rd_data=0 and rd_error=1; in-range reads SHALL return rd_error=0.
REQ-032 Memory reads SHALL occur only on accepted requests; the array read port SHALL be enabled only on acceptance.

Reset
REQ-033 On rst_n low, all stage valids, rd_resp_valid, rd_error and rd_data SHALL clear to 0 asynchronously.
REQ-034 Memory contents SHALL NOT be reset; in-flight reads at reset SHALL be discarded.
REQ-035 Writes SHALL be ignored while rst_n is low; a request presented during reset SHALL NOT be accepted.

Structure
REQ-036 Package byte_write_ram_pkg SHALL hold rdw_mode_e (READ_FIRST, WRITE_FIRST) and word-index/lane-count helper functions.
REQ-037 Sub-module byte_write_ram_core SHALL hold the array, per-lane write and enabled registered read; the pipeline, bypass and handshake logic SHALL be in the top.

Verification
REQ-038 Write 0xDEADBEEF to byte address 0x08 with strobe 0xF, then write 0x11223344 with strobe 0x5, then read 0x08 -> rd_data=0xDE22BE44, rd_error=0.
REQ-039 READ_LATENCY=2, back-to-back reads of 0x00,0x04,0x08 with rd_resp_ready=1 -> responses on cycles +2,+3,+4 in order.
REQ-040 Hold rd_resp_ready=0 for 5 cycles during streaming reads -> rd_req_ready drops once pipeline is full, held response stable, no loss after release.
REQ-041 Same-cycle write 0xAAAAAAAA (strobe 0x3) and read to a word holding 0x12345678 -> READ_FIRST 0x12345678; WRITE_FIRST 0x1234AAAA.
REQ-042 ADDR_DEPTH=32, read byte address 0x80 -> rd_data=0, rd_error=1; write to 0x80 leaves word 0 unchanged.
REQ-043 Assert rst_n low with two reads in flight -> rd_resp_valid=0 immediately; no stale responses after release.
